bf16_acc: RTL and testbench

- Streaming bf16 accumulator that feeds the combinational bf16 adder and consumes its result.
- Accepts a frame of bf16 operands on a valid/ready input stream. Presents {running sum, new operand} to an external adder each accepted beat and registers the adder result back as the running sum.
- On the frame's last beat, emits the final sum on a valid/ready output stream with beat count and a sticky NaN flag.
- Sits between the vector datapath (producer) and the bf16_add instance (placed alongside, combinational).

---
 rtl/bf16_acc_if.sv | 50 +++++
 rtl/bf16_acc.sv | 198 +++++++++++++++++++
 tb/tb_bf16_acc.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bf16_acc_if.sv
// Stream, adder-side and result signals of the bf16 accumulator.
// The slave modport is the accumulator; the master is the producer, adder and consumer side.
interface bf16_acc_if #(
    parameter int E     = 8,
    parameter int M     = 7,
    parameter int CNT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic             in_s_i;
    logic [E-1:0]     in_e_i;
    logic [M-1:0]     in_m_i;
    logic             in_last_i;

    logic             add_sa_o;
    logic [E-1:0]     add_ea_o;
    logic [M-1:0]     add_ma_o;
    logic             add_sb_o;
    logic [E-1:0]     add_eb_o;
    logic [M-1:0]     add_mb_o;
    logic             add_s_i;
    logic [E-1:0]     add_e_i;
    logic [M-1:0]     add_m_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic             out_s_o;
    logic [E-1:0]     out_e_o;
    logic [M-1:0]     out_m_o;
    logic [CNT_W-1:0] out_cnt_o;
    logic             out_nan_o;

    modport slave (
        input  in_valid_i, in_s_i, in_e_i, in_m_i, in_last_i,
        input  add_s_i, add_e_i, add_m_i,
        input  out_ready_i,
        output in_ready_o,
        output add_sa_o, add_ea_o, add_ma_o, add_sb_o, add_eb_o, add_mb_o,
        output out_valid_o, out_s_o, out_e_o, out_m_o, out_cnt_o, out_nan_o
    );

    modport master (
        output in_valid_i, in_s_i, in_e_i, in_m_i, in_last_i,
        output add_s_i, add_e_i, add_m_i,
        output out_ready_i,
        input  in_ready_o,
        input  add_sa_o, add_ea_o, add_ma_o, add_sb_o, add_eb_o, add_mb_o,
        input  out_valid_o, out_s_o, out_e_o, out_m_o, out_cnt_o, out_nan_o
    );
endinterface

// File: rtl/bf16_acc.sv
// Streaming bf16 frame accumulator driving an external combinational adder.
// A frame's sum is held on the output stream with its beat count and a sticky NaN flag.
module bf16_acc #(
    parameter int E     = 8,
    parameter int M     = 7,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        nreset,
    bf16_acc_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_in_ready;
    logic             r_acc_s;
    logic [E-1:0]     r_acc_e;
    logic [M-1:0]     r_acc_m;
    logic [CNT_W-1:0] r_cnt;
    logic             r_nan;

    logic             r_out_valid;
    logic             r_out_s;
    logic [E-1:0]     r_out_e;
    logic [M-1:0]     r_out_m;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_nan;

    logic             w_in_s;
    logic [E-1:0]     w_in_e;
    logic [M-1:0]     w_in_m;
    logic             w_in_nan;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_inc;

    // Canonical quiet NaN presented whenever the frame saw a NaN operand.
    function automatic logic [E+M:0] fmt_out(input logic nan, input logic s,
                                             input logic [E-1:0] e, input logic [M-1:0] m);
        logic [E+M:0] res;
        if (nan) begin
            res = {1'b0, {E{1'b1}}, {M{1'b1}}};
        end else begin
            res = {s, e, m};
        end
        return res;
    endfunction

    // Flush subnormal operands to signed zero and classify NaN on the raw operand.
    always_comb begin
        w_in_s   = bus.in_s_i;
        w_in_e   = bus.in_e_i;
        w_in_m   = bus.in_m_i;
        w_in_nan = (bus.in_e_i == {E{1'b1}}) && (bus.in_m_i != {M{1'b0}});
        if (bus.in_e_i == {E{1'b0}}) begin
            w_in_m = {M{1'b0}};
        end else begin
            w_in_m = bus.in_m_i;
        end
    end

    // Handshake qualifier and saturating beat count.
    always_comb begin
        w_accept = bus.in_valid_i & r_in_ready;
        if (r_cnt == {CNT_W{1'b1}}) begin
            w_cnt_inc = r_cnt;
        end else begin
            w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state logic for the frame FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = bus.in_last_i ? ST_HOLD : ST_ACC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (w_accept && bus.in_last_i) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Running sum, beat count, NaN flag and held result registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_in_ready  <= 1'b0;
            r_acc_s     <= 1'b0;
            r_acc_e     <= {E{1'b0}};
            r_acc_m     <= {M{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_nan       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_s     <= 1'b0;
            r_out_e     <= {E{1'b0}};
            r_out_m     <= {M{1'b0}};
            r_out_cnt   <= {CNT_W{1'b0}};
            r_out_nan   <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt != ST_HOLD);
            r_out_valid <= (w_state_nxt == ST_HOLD);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                        r_nan <= w_in_nan;
                        if (bus.in_last_i) begin
                            {r_out_s, r_out_e, r_out_m} <= fmt_out(w_in_nan, w_in_s, w_in_e, w_in_m);
                            r_out_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                            r_out_nan <= w_in_nan;
                        end else begin
                            r_acc_s <= w_in_s;
                            r_acc_e <= w_in_e;
                            r_acc_m <= w_in_m;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_inc;
                        r_nan <= r_nan | w_in_nan;
                        if (bus.in_last_i) begin
                            {r_out_s, r_out_e, r_out_m} <= fmt_out(r_nan | w_in_nan,
                                                                   bus.add_s_i, bus.add_e_i, bus.add_m_i);
                            r_out_cnt <= w_cnt_inc;
                            r_out_nan <= r_nan | w_in_nan;
                        end else begin
                            r_acc_s <= bus.add_s_i;
                            r_acc_e <= bus.add_e_i;
                            r_acc_m <= bus.add_m_i;
                        end
                    end
                end
                ST_HOLD: begin
                    // The held result stays put; only the frame state is cleared on release.
                    if (bus.out_ready_i) begin
                        r_acc_s <= 1'b0;
                        r_acc_e <= {E{1'b0}};
                        r_acc_m <= {M{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                        r_nan   <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                    r_nan <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = r_in_ready;
    assign bus.add_sa_o    = r_acc_s;
    assign bus.add_ea_o    = r_acc_e;
    assign bus.add_ma_o    = r_acc_m;
    assign bus.add_sb_o    = w_in_s;
    assign bus.add_eb_o    = w_in_e;
    assign bus.add_mb_o    = w_in_m;
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_s_o     = r_out_s;
    assign bus.out_e_o     = r_out_e;
    assign bus.out_m_o     = r_out_m;
    assign bus.out_cnt_o   = r_out_cnt;
    assign bus.out_nan_o   = r_out_nan;
endmodule

// File: tb/tb_bf16_acc.sv
// Scoreboard bench for bf16_acc with a real-valued bf16 adder model hung on the adder port.
module tb_bf16_acc;
    logic clk;
    logic nreset;

    bf16_acc_if #(.E(8), .M(7), .CNT_W(16)) bus ();

    bf16_acc #(.E(8), .M(7), .CNT_W(16)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    typedef struct {
        logic [15:0] data;
        int          cnt;
        logic        nan;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk;
    int          n_fail;
    logic [15:0] sb_acc;
    int          sb_cnt;
    logic        sb_nan;
    logic        sb_first;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] flush(input logic [15:0] v);
        return (v[14:7] == 8'h00) ? {v[15], 15'h0000} : v;
    endfunction

    function automatic logic is_nan(input logic [15:0] v);
        return (v[14:7] == 8'hFF) && (v[6:0] != 7'h00);
    endfunction

    function automatic real bf2r(input logic [15:0] b);
        real v;
        int  e;
        e = int'(b[14:7]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(int'(b[6:0])) / 128.0;
        for (int i = 0; i < e - 127; i++) v = v * 2.0;
        for (int i = 0; i < 127 - e; i++) v = v / 2.0;
        return b[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic       s;
        real        mag;
        int         ex;
        int         mant;
        logic [7:0] e8;
        logic [6:0] m7;
        s   = (r < 0.0);
        mag = s ? -r : r;
        if (mag == 0.0) return {s, 15'h0000};
        ex = 127;
        while (mag >= 2.0 && ex < 254) begin mag = mag / 2.0; ex++; end
        while (mag < 1.0 && ex > 1) begin mag = mag * 2.0; ex--; end
        mant = $rtoi((mag - 1.0) * 128.0);
        e8   = ex[7:0];
        m7   = mant[6:0];
        return {s, e8, m7};
    endfunction

    function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
        if (is_nan(a) || is_nan(b)) return 16'h7FC0;
        return r2bf(bf2r(a) + bf2r(b));
    endfunction

    // Combinational adder model on the accumulator's adder port.
    always_comb begin
        {bus.add_s_i, bus.add_e_i, bus.add_m_i} =
            bf_add({bus.add_sa_o, bus.add_ea_o, bus.add_ma_o}, {bus.add_sb_o, bus.add_eb_o, bus.add_mb_o});
    end

    // Result monitor: every completed output handshake is checked against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (nreset && bus.out_valid_o && bus.out_ready_i) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_data", {16'h0, bus.out_s_o, bus.out_e_o, bus.out_m_o}, {16'h0, e.data});
                check("out_cnt", {16'h0, bus.out_cnt_o}, e.cnt);
                check("out_nan", {31'h0, bus.out_nan_o}, {31'h0, e.nan});
            end
        end
    end

    task automatic set_in(input logic [15:0] v, input logic last);
        bus.in_valid_i = 1'b1;
        {bus.in_s_i, bus.in_e_i, bus.in_m_i} = v;
        bus.in_last_i = last;
    endtask

    // Drives one beat (called just after a rising edge) and updates the reference model on acceptance.
    task automatic beat(input logic [15:0] v, input logic last);
        int   n;
        logic [15:0] fv;
        fv = flush(v);
        set_in(v, last);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready_o) begin
            check("in_ready_timeout", {31'h0, bus.in_ready_o}, 32'd1);
            bus.in_valid_i = 1'b0;
        end else begin
            if (!sb_first) begin
                check("add_a", {16'h0, bus.add_sa_o, bus.add_ea_o, bus.add_ma_o}, {16'h0, sb_acc});
                check("add_b", {16'h0, bus.add_sb_o, bus.add_eb_o, bus.add_mb_o}, {16'h0, fv});
            end
            @(posedge clk);
            #1;
            bus.in_valid_i = 1'b0;
            if (sb_first) begin
                sb_acc = fv;
                sb_cnt = 1;
                sb_nan = is_nan(v);
            end else begin
                sb_acc = bf_add(sb_acc, fv);
                sb_cnt = (sb_cnt == 65535) ? sb_cnt : sb_cnt + 1;
                sb_nan = sb_nan | is_nan(v);
            end
            if (last) begin
                sb_q.push_back('{data: (sb_nan ? 16'h7FFF : sb_acc), cnt: sb_cnt, nan: sb_nan});
                sb_first = 1'b1;
                check("valid_after_last", {31'h0, bus.out_valid_o}, 32'd1);
                check("ready_low_hold", {31'h0, bus.in_ready_o}, 32'd0);
            end else begin
                sb_first = 1'b0;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        sb_first = 1'b1;
        sb_acc   = 16'h0000;
        sb_cnt   = 0;
        sb_nan   = 1'b0;
        nreset   = 1'b0;
        bus.out_ready_i = 1'b1;
        set_in(16'h3F80, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'h0, bus.in_ready_o}, 32'd0);
        check("rst_out_valid", {31'h0, bus.out_valid_o}, 32'd0);
        check("rst_out_data", {16'h0, bus.out_s_o, bus.out_e_o, bus.out_m_o}, 32'd0);
        check("rst_out_cnt", {16'h0, bus.out_cnt_o}, 32'd0);
        check("rst_out_nan", {31'h0, bus.out_nan_o}, 32'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", {31'h0, bus.in_ready_o}, 32'd1);
        check("rel_no_output", {31'h0, bus.out_valid_o}, 32'd0);
        bus.in_valid_i = 1'b0;
        @(posedge clk); #1;

        beat(16'h3F80, 1'b0);
        beat(16'h4000, 1'b1);
        @(posedge clk); #1;
        beat(16'hC040, 1'b1);
        @(posedge clk); #1;
        beat(16'h8001, 1'b1);
        @(posedge clk); #1;
        beat(16'h3F80, 1'b0);
        beat(16'h0005, 1'b0);
        beat(16'h4000, 1'b1);
        @(posedge clk); #1;
        beat(16'h3F80, 1'b0);
        beat(16'h7FC1, 1'b0);
        beat(16'h3F80, 1'b1);
        @(posedge clk); #1;
        beat(16'h4000, 1'b0);
        beat(16'hC040, 1'b1);
        @(posedge clk); #1;

        // Back-pressure: the held result must not move and the waiting operand must not be taken.
        bus.out_ready_i = 1'b0;
        beat(16'h3F80, 1'b1);
        set_in(16'h4000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'h0, bus.out_valid_o}, 32'd1);
            check("bp_data", {16'h0, bus.out_s_o, bus.out_e_o, bus.out_m_o}, 32'h3F80);
            check("bp_in_ready", {31'h0, bus.in_ready_o}, 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        beat(16'h4000, 1'b1);
        @(posedge clk); #1;

        // Reset in the middle of a frame drops the partial sum without producing output.
        beat(16'h3F80, 1'b0);
        nreset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'h0, bus.out_valid_o}, 32'd0);
        check("mid_rst_ready", {31'h0, bus.in_ready_o}, 32'd0);
        @(posedge clk); #1;
        nreset   = 1'b1;
        sb_first = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_rel_ready", {31'h0, bus.in_ready_o}, 32'd1);
        beat(16'h4000, 1'b0);
        beat(16'h3F80, 1'b1);

        repeat (5) @(posedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
